fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the CPU: owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned word plus PC+4 into the IF/ID pipeline register. Honors stall, flush and branch/jump redirect requests from the decode/execute stages. Sits between the hazard/branch logic (upstream control) and the decoder (downstream consumer of IF/ID).

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 32: instruction memory depth in words; fetch range is 0 .. 4*IMEM_WORDS-4.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- pc_addr_o  out  32  current PC, byte address to instruction memory.
- instr_i  in  32  instruction word returned combinationally for pc_addr_o.
- stall_i  in  1  hold PC and IF/ID contents.
- flush_i  in  1  replace next IF/ID contents with a bubble.
- redirect_i  in  1  load PC from redirect_pc_i; implies flush.
- redirect_pc_i  in  32  branch/jump target.
- ifid_instr_o  out  32  registered instruction.
- ifid_pc4_o  out  32  registered PC+4 of that instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- fault_o  out  1  sticky: misaligned redirect or out-of-range fetch seen.

## Operation
- Per-edge priority: rst_i > redirect_i > stall_i > flush_i > normal advance.
- Reset: PC=RESET_PC; ifid_instr_o=32'h0, ifid_pc4_o=0, ifid_valid_o=0, fault_o=0.
- Normal: PC<=PC+4; IF/ID<={instr_i, PC+4, valid=1}.
- Stall: PC and IF/ID unchanged.
- Flush (no redirect, no stall): PC<=PC+4; IF/ID<=bubble {32'h0, PC+4, valid=0}.
- Redirect: PC<={redirect_pc_i[31:2],2'b00}; IF/ID<=bubble; wins over simultaneous stall_i.
- Misalignment: redirect_pc_i[1:0]!=0 sets fault_o; target still truncated and used.
- Range: PC >= 4*IMEM_WORDS while not in reset sets fault_o; fetch continues, instruction captured as 32'h0 with valid=0.
- PC+4 arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is silent (range fault already raised).
- fault_o clears only on reset.

## Timing
- Fetch latency: 1 cycle; instruction at PC in cycle n appears on ifid_* in cycle n+1.
- pc_addr_o is a register output, valid from the first cycle after rst_i deasserts (=RESET_PC).
- First valid IF/ID word: second cycle after reset release.
- Redirect taken in cycle n: pc_addr_o=target in n+1; ifid_valid_o=0 in n+1; target instruction valid in n+2. Penalty: exactly one bubble.
- Stall held k cycles: outputs frozen k cycles, resume advancing on first cycle stall_i low.
- Reset asserted mid-run: all state returns to reset values on that edge regardless of other inputs.

## Configuration
- FETCH_PERF_EN defined: adds three 32-bit wrapping counters, reset to 0, exported as perf_fetch_o (edges with valid capture), perf_stall_o (edges with stall_i applied), perf_bubble_o (edges inserting a bubble via flush or redirect).
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package co_pkg: NOP_INSTR = 32'h0, word width 32, IF/ID bundle struct {instr, pc4, valid}.
- One sub-module: ifid_reg (bundle register with load/hold/bubble control); PC logic and fault tracking stay in fetch_stage.

## Test plan
- Reset release, memory holds 0x11111111,0x22222222 at words 0,1 -> pc_addr_o 0,4,8; ifid_instr_o 0x11111111 then 0x22222222 with pc4 4, 8, valid 1.
- stall_i high 3 cycles at PC=8 -> pc_addr_o stays 8, IF/ID unchanged 3 cycles, then advances to 12.
- redirect_i with target 0x40 at PC=12 -> next cycle pc_addr_o=0x40, valid=0; following cycle mem[16] valid, pc4 0x44.
- redirect_i and stall_i same edge, target 0x20 -> pc_addr_o=0x20, bubble inserted; fault_o stays 0.
- redirect target 0x22 -> pc_addr_o=0x20, fault_o=1 until rst_i; PC run to 0x80 with IMEM_WORDS=32 -> fault_o=1, valid=0.
- With FETCH_PERF_EN: 10 normal, 2 stall, 1 redirect edges -> perf_fetch_o=10, perf_stall_o=2, perf_bubble_o=1.

Source files
------------

// File: rtl/co_pkg.sv
// Shared CPU definitions: word width, NOP encoding and the IF/ID bundle.
package co_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    // A bubble keeps the sequential PC+4 so downstream link logic stays consistent.
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] pc4);
        ifid_t b;
        b.instr = NOP_INSTR;
        b.pc4   = pc4;
        b.valid = 1'b0;
        return b;
    endfunction
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: reset, hold, bubble insert or load, in that priority.
module ifid_reg
    import co_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  hold_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= ifid_bubble('0);
        end else if (!hold_i) begin
            q_o <= bubble_i ? ifid_bubble(d_i.pc4) : d_i;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, range/alignment fault tracking, IF/ID capture.
// Optional FETCH_PERF_EN adds fetch/stall/bubble event counters.
module fetch_stage
    import co_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_bubble_o,
`endif
    output logic        fault_o
);
    // 33-bit compare so a memory spanning the full address space cannot overflow.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        in_range;
    logic        misaligned;
    logic        hold;
    logic        bubble;
    ifid_t       cap;
    ifid_t       ifid;

    assign pc4        = pc + 32'd4;
    assign in_range   = {1'b0, pc} < IMEM_BYTES;
    assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    // Redirect overrides stall: the wrong-path word must never be held.
    assign hold       = stall_i && !redirect_i;
    assign bubble     = redirect_i || flush_i;

    always_comb begin
        cap.instr = in_range ? instr_i : NOP_INSTR;
        cap.pc4   = pc4;
        cap.valid = in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc      <= RESET_PC;
            fault_o <= 1'b0;
        end else begin
            if (redirect_i)
                pc <= {redirect_pc_i[31:2], 2'b00};
            else if (!stall_i)
                pc <= pc4;
            if (!in_range || misaligned)
                fault_o <= 1'b1;
        end
    end

    ifid_reg u_ifid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (hold),
        .bubble_i (bubble),
        .d_i      (cap),
        .q_o      (ifid)
    );

    assign pc_addr_o    = pc;
    assign ifid_instr_o = ifid.instr;
    assign ifid_pc4_o   = ifid.pc4;
    assign ifid_valid_o = ifid.valid;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_o  <= '0;
            perf_stall_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            if (!hold && !bubble && in_range)
                perf_fetch_o <= perf_fetch_o + 32'd1;
            if (hold)
                perf_stall_o <= perf_stall_o + 32'd1;
            if (!hold && bubble)
                perf_bubble_o <= perf_bubble_o + 32'd1;
        end
    end
`endif
endmodule
